// File: rtl/dual_shift_ctrl_pkg.sv
// Shared types and constants for the dual shift-register sequencer.
package dual_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/dual_shift_ctrl_sat_counter.sv
// Saturating error counter with synchronous active-low clear; holds at all-ones.
module sat_counter
  import dual_shift_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 inc,
  output logic [ERR_CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != ERR_CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dual_shift_ctrl.sv
// Sequencer for a redundant dual shift-register pair: serialise, flush, check XOR.
// Optional abort input enabled by defining DUAL_SHIFT_CTRL_ABORT_EN.
module dual_shift_ctrl
  import dual_shift_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SR_LEN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_word,
`ifdef DUAL_SHIFT_CTRL_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_ce,
  output logic                 o_data,
  input  logic                 i_xor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int BIT_W   = $clog2(WIDTH + 1);
  localparam int FLUSH_W = $clog2(SR_LEN + 2);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SR_LEN);

  state_t               state;
  state_t               state_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_next;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic [FLUSH_W-1:0]   flush_cnt_next;
  logic [WIDTH-1:0]     sreg;
  logic [WIDTH-1:0]     sreg_next;
  logic                 err_next;
  logic                 busy_next;
  logic                 abort_req;

`ifdef DUAL_SHIFT_CTRL_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Handshake: a word transfers on a rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE, and i_valid without o_ready is just a stall.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    flush_cnt_next = flush_cnt;
    sreg_next      = sreg;
    err_next       = o_err;
    case (state)
      S_IDLE: begin
        if (i_valid && o_ready) begin
          state_next   = S_SHIFT;
          sreg_next    = i_word;
          bit_cnt_next = '0;
          err_next     = 1'b0;
        end
      end
      S_SHIFT: begin
        if (i_xor) err_next = 1'b1;
        sreg_next    = sreg >> 1;
        bit_cnt_next = bit_cnt + 1'b1;
        if ((bit_cnt == BIT_LAST) || abort_req) begin
          state_next     = S_FLUSH;
          flush_cnt_next = '0;
        end
      end
      S_FLUSH: begin
        if (i_xor) err_next = 1'b1;
        flush_cnt_next = flush_cnt + 1'b1;
        if (flush_cnt == FLUSH_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy_next = (state_next == S_SHIFT) || (state_next == S_FLUSH);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      flush_cnt <= '0;
      sreg      <= '0;
      o_ce      <= 1'b0;
      o_busy    <= 1'b0;
      o_data    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      flush_cnt <= flush_cnt_next;
      sreg      <= sreg_next;
      o_ce      <= busy_next;
      o_busy    <= busy_next;
      o_data    <= (state_next == S_SHIFT) && sreg_next[0];
      o_done    <= (state_next == S_DONE);
      o_err     <= err_next;
      o_ready   <= (state_next == S_IDLE);
    end
  end

  sat_counter u_err_cnt (
    .clk     (i_clk),
    .clear_n (i_reset_n),
    .inc     ((state == S_DONE) && o_err),
    .count   (o_err_cnt)
  );

endmodule
